// File: rtl/aclk_pkg.sv
// Shared constants, types and helpers for the aclk_* alarm clock blocks.
package aclk_pkg;

    localparam int unsigned BCD_W             = 4;
    localparam int unsigned MAX_HR_TENS       = 2;
    localparam int unsigned MAX_HR_UNITS_AT_2 = 3;
    localparam int unsigned MAX_MIN_TENS      = 5;
    localparam int unsigned MAX_UNITS         = 9;
    localparam int unsigned NOKEY             = 10;

    typedef logic [BCD_W-1:0] bcd_t;

    // Controller state encodings shared across the alarm clock blocks.
    typedef enum logic [2:0] {
        StShowTime,
        StKeyEntry,
        StKeyStored,
        StShowAlarm,
        StSetAlarmTime,
        StSetCurrentTime,
        StKeyWaited
    } aclk_ctrl_state_e;

    // True when the four keyed digits form a legal 24 h HH:MM value.
    function automatic logic bcd_time_valid(input bcd_t ms_hr, input bcd_t ls_hr,
                                            input bcd_t ms_min, input bcd_t ls_min);
        logic ok;
        ok = (ms_hr <= BCD_W'(MAX_HR_TENS)) && (ls_hr <= BCD_W'(MAX_UNITS)) &&
             (ms_min <= BCD_W'(MAX_MIN_TENS)) && (ls_min <= BCD_W'(MAX_UNITS));
        if (ms_hr == BCD_W'(MAX_HR_TENS) && ls_hr > BCD_W'(MAX_HR_UNITS_AT_2)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/aclk_time_counter_if.sv
// Signal bundle between the controller/keypad side and the current-time counter.
interface aclk_time_counter_if;
    import aclk_pkg::*;

    logic one_second;
    logic reset_count;
    logic load_new_c;
    bcd_t new_time_ms_hr;
    bcd_t new_time_ls_hr;
    bcd_t new_time_ms_min;
    bcd_t new_time_ls_min;
    bcd_t cur_time_ms_hr;
    bcd_t cur_time_ls_hr;
    bcd_t cur_time_ms_min;
    bcd_t cur_time_ls_min;
    logic [5:0] sec_count;
    logic one_minute;
    logic load_err;

    // Controller / time generator side.
    modport master (
        output one_second, reset_count, load_new_c,
        output new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
        input  cur_time_ms_hr, cur_time_ls_hr, cur_time_ms_min, cur_time_ls_min,
        input  sec_count, one_minute, load_err
    );

    // Time counter side.
    modport slave (
        input  one_second, reset_count, load_new_c,
        input  new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
        output cur_time_ms_hr, cur_time_ls_hr, cur_time_ms_min, cur_time_ls_min,
        output sec_count, one_minute, load_err
    );

endinterface

// File: rtl/aclk_bcd_digit.sv
// One BCD digit register with load, clear and increment-with-wrap; carry_o is
// high when an increment wraps this digit back to 0.
module aclk_bcd_digit
    import aclk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic clear_i,
    input  logic inc_i,
    input  bcd_t wrap_i,
    output bcd_t q_o,
    output logic carry_o
);

    bcd_t q_q;
    bcd_t q_d;

    // >= rather than == so an out-of-range value can never count further upward.
    assign carry_o = inc_i && (q_q >= wrap_i);
    assign q_o     = q_q;

    // Next-state: load beats clear beats increment.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (clear_i) begin
            q_d = '0;
        end else if (inc_i) begin
            q_d = (q_q >= wrap_i) ? '0 : q_q + 4'd1;
        end
    end

    // Digit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/aclk_time_counter.sv
// Current-time keeper: counts one_second ticks into seconds and BCD HH:MM (24 h),
// loads keyed digits from the controller and flags rejected loads.
// Optional feature macro: ACLK_FAST_WATCH_EN adds the fast_watch input, which makes
// each tick advance one minute directly.
module aclk_time_counter
    import aclk_pkg::*;
#(
    parameter int unsigned SEC_PER_MIN = 60
) (
    input  logic clk,
    input  logic reset,
`ifdef ACLK_FAST_WATCH_EN
    input  logic fast_watch,
`endif
    aclk_time_counter_if.slave tc
);

    localparam logic [5:0] SecLast = 6'(SEC_PER_MIN - 1);

    logic [5:0] sec_q, sec_d;
    logic       one_minute_q, one_minute_d;
    logic       load_err_q, load_err_d;
    logic       min_adv;
    logic       load_ok;
    logic       fast_mode;

    bcd_t ms_hr, ls_hr, ms_min, ls_min;
    bcd_t ls_hr_wrap;
    logic c_ls_min, c_ms_min, c_ls_hr, c_ms_hr;

`ifdef ACLK_FAST_WATCH_EN
    assign fast_mode = fast_watch;
`else
    assign fast_mode = 1'b0;
`endif

    assign load_ok    = bcd_time_valid(tc.new_time_ms_hr, tc.new_time_ls_hr,
                                       tc.new_time_ms_min, tc.new_time_ls_min);
    assign ls_hr_wrap = (ms_hr == BCD_W'(MAX_HR_TENS)) ? BCD_W'(MAX_HR_UNITS_AT_2)
                                                       : BCD_W'(MAX_UNITS);

    // Seconds counting and minute-advance decision; load/reset_count drop the tick.
    always_comb begin
        sec_d        = sec_q;
        min_adv      = 1'b0;
        one_minute_d = 1'b0;
        load_err_d   = tc.load_new_c && !load_ok;
        if (tc.load_new_c || tc.reset_count) begin
            sec_d = '0;
        end else if (fast_mode) begin
            sec_d   = '0;
            min_adv = tc.one_second;
        end else if (tc.one_second) begin
            if (sec_q >= SecLast) begin
                sec_d   = '0;
                min_adv = 1'b1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        one_minute_d = min_adv;
    end

    // Seconds and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sec_q        <= '0;
            one_minute_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            sec_q        <= sec_d;
            one_minute_q <= one_minute_d;
            load_err_q   <= load_err_d;
        end
    end

    // Carry chain: minutes units -> minutes tens -> hours units -> hours tens.
    // The hours-tens carry is the day wrap; it clears every digit explicitly.
    aclk_bcd_digit u_ls_min (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tc.load_new_c && load_ok),
        .load_val_i (tc.new_time_ls_min),
        .clear_i    (c_ms_hr),
        .inc_i      (min_adv),
        .wrap_i     (BCD_W'(MAX_UNITS)),
        .q_o        (ls_min),
        .carry_o    (c_ls_min)
    );

    aclk_bcd_digit u_ms_min (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tc.load_new_c && load_ok),
        .load_val_i (tc.new_time_ms_min),
        .clear_i    (c_ms_hr),
        .inc_i      (c_ls_min),
        .wrap_i     (BCD_W'(MAX_MIN_TENS)),
        .q_o        (ms_min),
        .carry_o    (c_ms_min)
    );

    aclk_bcd_digit u_ls_hr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tc.load_new_c && load_ok),
        .load_val_i (tc.new_time_ls_hr),
        .clear_i    (c_ms_hr),
        .inc_i      (c_ms_min),
        .wrap_i     (ls_hr_wrap),
        .q_o        (ls_hr),
        .carry_o    (c_ls_hr)
    );

    aclk_bcd_digit u_ms_hr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tc.load_new_c && load_ok),
        .load_val_i (tc.new_time_ms_hr),
        .clear_i    (c_ms_hr),
        .inc_i      (c_ls_hr),
        .wrap_i     (BCD_W'(MAX_HR_TENS)),
        .q_o        (ms_hr),
        .carry_o    (c_ms_hr)
    );

    assign tc.cur_time_ms_hr  = ms_hr;
    assign tc.cur_time_ls_hr  = ls_hr;
    assign tc.cur_time_ms_min = ms_min;
    assign tc.cur_time_ls_min = ls_min;
    assign tc.sec_count       = sec_q;
    assign tc.one_minute      = one_minute_q;
    assign tc.load_err        = load_err_q;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Self-checking bench for aclk_time_counter (SEC_PER_MIN = 4): a minutes-of-day
// model checked every cycle plus literal expectations at the directed points.
module tb_aclk_time_counter;

    localparam int SPM = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
`ifdef ACLK_FAST_WATCH_EN
    logic fast_watch = 1'b0;
`endif

    aclk_time_counter_if tc_if ();

    aclk_time_counter #(
        .SEC_PER_MIN (SPM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ACLK_FAST_WATCH_EN
        .fast_watch (fast_watch),
`endif
        .tc         (tc_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time as minutes-of-day, seconds as a plain integer.
    int m_min = 0;
    int m_sec = 0;
    bit m_pulse = 1'b0;
    bit m_err = 1'b0;

    function automatic bit keyed_valid(input int a, input int b, input int c, input int d);
        return (a <= 9) && (b <= 9) && (c <= 5) && (d <= 9) && (a * 10 + b <= 23);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_min <= 0; m_sec <= 0; m_pulse <= 1'b0; m_err <= 1'b0;
        end else begin
            m_pulse <= 1'b0;
            m_err   <= 1'b0;
            if (tc_if.load_new_c) begin
                m_sec <= 0;
                if (keyed_valid(int'(tc_if.new_time_ms_hr), int'(tc_if.new_time_ls_hr),
                                int'(tc_if.new_time_ms_min), int'(tc_if.new_time_ls_min)))
                    m_min <= (int'(tc_if.new_time_ms_hr) * 10 + int'(tc_if.new_time_ls_hr)) * 60
                             + int'(tc_if.new_time_ms_min) * 10 + int'(tc_if.new_time_ls_min);
                else
                    m_err <= 1'b1;
            end else if (tc_if.reset_count) begin
                m_sec <= 0;
`ifdef ACLK_FAST_WATCH_EN
            end else if (fast_watch) begin
                m_sec <= 0;
                if (tc_if.one_second) begin
                    m_min   <= (m_min + 1) % 1440;
                    m_pulse <= 1'b1;
                end
`endif
            end else if (tc_if.one_second) begin
                if (m_sec == SPM - 1) begin
                    m_sec   <= 0;
                    m_min   <= (m_min + 1) % 1440;
                    m_pulse <= 1'b1;
                end else begin
                    m_sec <= m_sec + 1;
                end
            end
        end
    end

    function automatic logic [23:0] model_vec();
        int h, mi;
        h  = m_min / 60;
        mi = m_min % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 6'(m_sec), m_pulse, m_err};
    endfunction

    logic [23:0] dut_vec;
    assign dut_vec = {tc_if.cur_time_ms_hr, tc_if.cur_time_ls_hr, tc_if.cur_time_ms_min,
                      tc_if.cur_time_ls_min, tc_if.sec_count, tc_if.one_minute, tc_if.load_err};

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) check("model", dut_vec, model_vec());
    end

    function automatic logic [23:0] lit(input int a, input int b, input int c, input int d,
                                        input int s, input bit p, input bit e);
        return {4'(a), 4'(b), 4'(c), 4'(d), 6'(s), p, e};
    endfunction

    // Apply one cycle of inputs at the negedge, then wait for the next negedge.
    task automatic drive(input logic ld, input logic rc, input logic tk,
                         input int a, input int b, input int c, input int d);
        tc_if.load_new_c      = ld;
        tc_if.reset_count     = rc;
        tc_if.one_second      = tk;
        tc_if.new_time_ms_hr  = 4'(a);
        tc_if.new_time_ls_hr  = 4'(b);
        tc_if.new_time_ms_min = 4'(c);
        tc_if.new_time_ls_min = 4'(d);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        drive(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        drive(1'b1, 1'b1, 1'b0, a, b, c, d);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        idle();
        check_en = 1'b1;
        check("reset_state", dut_vec, lit(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        idle();

        // Minute rollover from 00:00 after SPM ticks.
        repeat (SPM - 1) tick();
        check("sec_before_wrap", dut_vec, lit(0, 0, 0, 0, 3, 0, 0));
        tick();
        check("first_minute", dut_vec, lit(0, 0, 0, 1, 0, 1, 0));
        idle();
        check("pulse_one_cycle", dut_vec, lit(0, 0, 0, 1, 0, 0, 0));

        // Day wrap and hour carries.
        load(2, 3, 5, 9);
        check("load_2359", dut_vec, lit(2, 3, 5, 9, 0, 0, 0));
        repeat (SPM) tick();
        check("day_wrap", dut_vec, lit(0, 0, 0, 0, 0, 1, 0));
        load(0, 9, 5, 9);
        repeat (SPM) tick();
        check("hr_09_10", dut_vec, lit(1, 0, 0, 0, 0, 1, 0));
        load(1, 9, 5, 9);
        repeat (SPM) tick();
        check("hr_19_20", dut_vec, lit(2, 0, 0, 0, 0, 1, 0));

        // Rejected load 24:00 after two ticks.
        tick();
        tick();
        load(2, 4, 0, 0);
        check("load_err_2400", dut_vec, lit(2, 0, 0, 0, 0, 0, 1));
        idle();
        check("load_err_clear", dut_vec, lit(2, 0, 0, 0, 0, 0, 0));
        load(1, 2, 6, 0);
        check("load_err_min", dut_vec, lit(2, 0, 0, 0, 0, 0, 1));
        load(1, 10, 0, 0);
        load(9, 0, 0, 0);

        // Load coincident with a tick at sec 3: tick dropped, no pulse.
        repeat (3) tick();
        drive(1'b1, 1'b1, 1'b1, 1, 2, 3, 4);
        check("load_with_tick", dut_vec, lit(1, 2, 3, 4, 0, 0, 0));

        // reset_count alone with a coincident tick.
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
        check("reset_count", dut_vec, lit(1, 2, 3, 4, 0, 0, 0));

        // one_second held high counts every cycle; minute tens carry.
        load(1, 2, 5, 9);
        repeat (2 * SPM) tick();
        check("held_tick", dut_vec, lit(1, 3, 0, 1, 0, 1, 0));

        // Reset in the middle of a count at 13:47.
        load(1, 3, 4, 7);
        tick();
        tick();
        reset = 1'b0;
        idle();
        check("mid_count_reset", dut_vec, lit(0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        idle();

`ifdef ACLK_FAST_WATCH_EN
        load(1, 1, 5, 8);
        fast_watch = 1'b1;
        tick();
        check("fast_1", dut_vec, lit(1, 1, 5, 9, 0, 1, 0));
        tick();
        tick();
        check("fast_3", dut_vec, lit(1, 2, 0, 1, 0, 1, 0));
        fast_watch = 1'b0;
        idle();
`endif

        repeat (2) idle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
